// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-path sizing: default widths, queue depth and the
// occupancy-counter width derived from the depth.
package instr_fetch_queue_pkg;

   localparam int AW_DEF    = 8;
   localparam int DW_DEF    = 16;
   localparam int DEPTH_DEF = 4;

   // Occupancy must represent 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int CW_DEF = cnt_w(DEPTH_DEF);

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO holding {word, address} fetch entries,
// with synchronous clear taking priority over push/pop.
module fetch_fifo
   import instr_fetch_queue_pkg::*;
#(
   parameter int W     = DW_DEF + AW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            cnt <= cnt + 1'b1;
         end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;

   // The issue side reserves a slot before fetching, so a full push is a bug.
   assert property (@(posedge clk) disable iff (!rst)
      (push && !clear) |-> (cnt != FULL));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues instruction-memory reads at pc, tracks the
// in-flight read, queues returned words and flushes on redirect.
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc,
   input  logic          flush,
   output logic [AW-1:0] mem_addr,
   output logic          mem_en,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic          pc_stall,
   output logic [CW-1:0] count
);

   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   logic          pend_valid;
   logic [AW-1:0] pend_pc;
   logic [CW:0]   occupancy;
   logic          push;
   logic          pop;

   // A slot is reserved at issue time, so the in-flight read counts.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, pend_valid};
   assign pc_stall  = occupancy >= LIMIT;

   assign mem_addr = pc;
   assign mem_en   = !pc_stall && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else begin
         pend_valid <= mem_en;
         if (mem_en) begin
            pend_pc <= pc;
         end
      end
   end

   assign push        = pend_valid && !flush;
   assign instr_valid = (count != '0) && !flush;
   assign pop         = instr_valid && instr_ready;

   fetch_fifo #(
      .W     (DW + AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata ({mem_rdata, pend_pc}),
      .rdata ({instr, instr_pc}),
      .count (count)
   );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised scoreboard bench for instr_fetch_queue against a
// queue-based model of issued, queued and delivered fetches.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [7:0]  pc;
   logic        flush;
   logic [7:0]  mem_addr;
   logic        mem_en;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_stall;
   logic [2:0]  count;

   instr_fetch_queue #(
      .AW    (8),
      .DW    (16),
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .flush       (flush),
      .mem_addr    (mem_addr),
      .mem_en      (mem_en),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_stall    (pc_stall),
      .count       (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [15:0] memarr [256];

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= memarr[mem_addr];
   end

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, got, exp, $time);
   endtask

   typedef struct {
      logic [15:0] w;
      logic [7:0]  a;
   } exp_t;

   exp_t q[$];
   bit   last_issue = 1'b0;
   int   ec;
   bit   es;
   exp_t e;

   // Model: every issued fetch is owed to decode in issue order unless a
   // flush intervenes; the newest issue is still in flight for one cycle.
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         last_issue = 1'b0;
      end else begin
         ec = q.size() - int'(last_issue);
         es = q.size() >= DEPTH;
         chk("count", 32'(count), 32'(ec));
         chk("pc_stall", 32'(pc_stall), 32'(es));
         chk("mem_en", 32'(mem_en), 32'(!es && !flush));
         chk("instr_valid", 32'(instr_valid), 32'(ec != 0 && !flush));
         if (mem_en) chk("mem_addr", 32'(mem_addr), 32'(pc));
         if (flush) begin
            q.delete();
            last_issue = 1'b0;
         end else begin
            if (instr_valid && instr_ready) begin
               chk("pop_has_expected", 32'(q.size() != 0), 32'd1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("instr", 32'(instr), 32'(e.w));
                  chk("instr_pc", 32'(instr_pc), 32'(e.a));
               end
            end
            if (mem_en) q.push_back('{w: memarr[pc], a: pc});
            last_issue = mem_en;
         end
      end
   end

   bit was_en = 1'b0;

   // Called just after a rising edge; behaves like a PC that advances
   // once per issued fetch and jumps to tgt on a redirect.
   task automatic step(input bit fl, input bit rdy, input logic [7:0] tgt);
      flush       = fl;
      instr_ready = rdy;
      if (fl) pc = tgt;
      else if (was_en) pc = pc + 8'd1;
      @(negedge clk);
      was_en = mem_en;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n;
   bit rmode;

   initial begin
      for (int i = 0; i < 256; i++) begin
         if (i < 64) memarr[i] = {8'hA0, 8'(i)};
         else memarr[i] = 16'($urandom);
      end
      rst         = 1'b0;
      pc          = 8'h05;
      flush       = 1'b0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc_stall", 32'(pc_stall), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);

      rst = 1'b1;
      @(negedge clk);
      chk("first_mem_en", 32'(mem_en), 32'd1);
      chk("first_mem_addr", 32'(mem_addr), 32'h05);
      was_en = mem_en;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 8'h00);
      chk("latency_valid", 32'(instr_valid), 32'd1);
      chk("latency_pc", 32'(instr_pc), 32'h05);

      repeat (10) step(1'b0, 1'b0, 8'h00);
      chk("bp_count_full", 32'(count), 32'd4);
      chk("bp_stall", 32'(pc_stall), 32'd1);
      repeat (8) step(1'b0, 1'b1, 8'h00);

      step(1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, 8'h00);
         chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
         chk("stream_no_stall", 32'(pc_stall), 32'd0);
         if (i >= 1) chk("stream_no_gap", 32'(instr_valid), 32'd1);
      end

      step(1'b1, 1'b0, 8'h10);
      n = 0;
      while (count != 3'd3 && n < 8) begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end
      chk("pp_count3", 32'(count), 32'd3);
      chk("pp_stall_pend", 32'(pc_stall), 32'd1);
      step(1'b0, 1'b1, 8'h00);
      chk("pp_count_held", 32'(count), 32'd3);
      step(1'b0, 1'b0, 8'h00);
      chk("fl_pre_count", 32'(count), 32'd3);
      chk("fl_pre_pend", 32'(pc_stall), 32'd1);

      step(1'b1, 1'b0, 8'h40);
      chk("fl_count0", 32'(count), 32'd0);
      chk("fl_valid0", 32'(instr_valid), 32'd0);
      flush = 1'b0;
      #1;
      chk("fl_redirect_en", 32'(mem_en), 32'd1);
      chk("fl_redirect_addr", 32'(mem_addr), 32'h40);
      @(negedge clk);
      was_en = mem_en;
      @(posedge clk);
      #1;
      step(1'b0, 1'b1, 8'h00);
      chk("fl_first_valid", 32'(instr_valid), 32'd1);
      chk("fl_first_pc", 32'(instr_pc), 32'h40);
      repeat (3) step(1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 8'h80);
         chk("hold_fl_en", 32'(mem_en), 32'd0);
         chk("hold_fl_count", 32'(count), 32'd0);
      end

      rmode = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 31) == 0) rmode = ~rmode;
         step($urandom_range(0, 13) == 0,
              rmode ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
              8'($urandom));
      end

      step(1'b1, 1'b0, 8'h20);
      n = 0;
      while (count != 3'd2 && n < 8) begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end
      chk("ar_pre_count", 32'(count), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_instr_valid", 32'(instr_valid), 32'd0);
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_pc_stall", 32'(pc_stall), 32'd0);
      chk("ar_instr", 32'(instr), 32'd0);
      chk("ar_instr_pc", 32'(instr_pc), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      was_en = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
              8'($urandom));
      end
      step(1'b0, 1'b1, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
